sa_tile_sequencer: RTL and testbench
====================================

# sa_tile_sequencer

Controller that sequences one tile computation on the `systolic_array` datapath. It loads an ARRAY_SIZE×ARRAY_SIZE weight tile row by row, latches the per-tile precision/sign configuration, and streams a programmable number of input vectors through the array. It tags the returning `psums` with a valid strobe aligned to the array's pipeline latency. It sits between the tile DMA/buffer logic and the array instance, and is the only driver of the array's inputs.

## Interface
- ARRAY_SIZE, 8, array dimension (rows = columns)
- PIPE_LAT, 1, cycles from `sa_inputs` change to the matching `sa_psums`; the array output register gives 1
- CNT_W, 16, width of the vector count

- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  tile start pulse; honoured in IDLE only
- cfg_in_width / cfg_weight_width  in  4 each  precision, latched on accepted start
- cfg_s_in / cfg_s_weight  in  1 each  signedness, latched on accepted start
- cfg_num_vecs  in  CNT_W  input vectors in the tile, latched on accepted start
- w_row_valid / w_row_ready  in/out  1  weight-row handshake
- w_row_data  in  ARRAY_SIZE×8  one weight row
- in_valid / in_ready  in/out  1  input-vector handshake
- in_data  in  ARRAY_SIZE×8  one input vector
- sa_weights  out  ARRAY_SIZE²×8  registered weight bank to the array
- sa_inputs  out  ARRAY_SIZE×8  registered input vector to the array
- sa_in_width / sa_weight_width  out  4  latched config to the array
- sa_s_in / sa_s_weight  out  1  latched config to the array
- sa_psums  in  ARRAY_SIZE×32  array output
- out_valid  out  1  `out_psums` holds a result for one accepted vector
- out_psums  out  ARRAY_SIZE×32  `sa_psums` passed through
- busy  out  1  high in LOAD_W, STREAM and DRAIN
- done  out  1  one-cycle pulse at tile end
- perf_bubbles  out  32  stall counter (see Configuration)

## Operation
- FSM states: IDLE, LOAD_W, STREAM, DRAIN, DONE.
- IDLE -> LOAD_W on `start`. The same edge latches all `cfg_*` inputs, clears the row counter and clears the vector counter.
- LOAD_W:
  - `w_row_ready` = 1.
  - Each handshake writes `w_row_data` into `sa_weights[r*ARRAY_SIZE +: ARRAY_SIZE]`, where r is the row counter, then increments r.
  - After row ARRAY_SIZE-1 is accepted: go to STREAM, or to DONE if `cfg_num_vecs` = 0.
- STREAM:
  - `in_ready` = 1.
  - Each handshake registers `in_data` onto `sa_inputs` and pushes a 1 into the valid shift register. Otherwise `sa_inputs` is driven to 0 and a 0 is pushed.
  - After accepting vector `cfg_num_vecs`-1: go to DRAIN.
- DRAIN: lasts PIPE_LAT+1 cycles (down-counter), pushes zeros, then goes to DONE.
- DONE: `done` = 1 for one cycle, then IDLE.
- `out_valid` = tail of the valid shift register, of length PIPE_LAT. `out_psums` = `sa_psums`, combinational.
- There is no output backpressure. The consumer must accept every `out_valid` cycle.
- Ready outputs are 0 in all states other than those listed above. The weight bank changes only in LOAD_W. `sa_*` config outputs are held from the latch until the next accepted start.
- Counter arithmetic is unsigned, with no wrap: counters stop at their terminal value.

## Timing
- Reset values: every output 0, including the `sa_weights` bank, the shift register and `perf_bubbles`; FSM in IDLE. Reset mid-tile aborts the tile and gives IDLE on the next cycle, with no `done` pulse.
- `start` outside IDLE is ignored. `start` asserted in the DONE cycle is ignored.
- `busy` rises in the cycle after an accepted start. It is low in DONE and IDLE.
- Input handshake at cycle t -> `sa_inputs` valid in t+1 -> `out_valid` in t+1+PIPE_LAT.
- The last `out_valid` falls in the final DRAIN cycle. `done` follows in the next cycle.
- Throughput is one vector per cycle while `in_valid` is held high.
- `cfg_num_vecs` = 0: `done` comes one cycle after the last weight row, with no `out_valid`.

## Configuration
- SA_CTRL_PERF_EN defined:
  - `perf_bubbles` counts STREAM cycles with `in_valid` = 0, saturating at 2³²-1.
  - It is cleared on an accepted start and holds its value after the tile.
- SA_CTRL_PERF_EN undefined: `perf_bubbles` is tied to 0 and no counter logic is built.

## Structure
- Shared package `sa_pkg` holds:
  - the state enum type `sa_state_t`
  - the default ARRAY_SIZE
  - a `sa_cfg_t` struct packing the two widths and two sign bits, reused by the latch and by later controllers.
- One sub-module: `sa_valid_pipe`, a PIPE_LAT-deep 1-bit shift register with synchronous clear.

## Test plan
- ARRAY_SIZE=8, PIPE_LAT=1, `cfg_num_vecs`=4, valids held high:
  - weights ready for 8 cycles, then inputs ready for 4 cycles
  - `out_valid` in 4 consecutive cycles, each 2 cycles after its accept
  - `done` 3 cycles after the last accept.
- Weight row r filled with value r+1 -> `sa_weights[r*8+c]` = r+1 for all c; other bank entries unchanged during STREAM.
- `in_valid` toggled 1,0,1,0 with `cfg_num_vecs`=2:
  - `sa_inputs` = 0 on bubble cycles
  - `out_valid` pattern 1,0,1
  - `perf_bubbles` = 1 with SA_CTRL_PERF_EN, 0 without.
- `cfg_num_vecs`=0 -> `done` one cycle after the 8th weight row; `in_ready` never asserted.
- `rst` asserted during STREAM after 2 vectors:
  - next cycle: IDLE, `busy`=0, `out_valid`=0, `sa_weights`=0, no `done`
  - a new start then completes normally.
- `start` pulsed during LOAD_W with different `cfg_in_width` -> ignored; `sa_in_width` keeps the first latched value.

Source files
------------

// File: rtl/sa_pkg.sv
// Shared types for the systolic-array controllers: FSM state encoding,
// default array dimension and the per-tile precision/sign configuration.
package sa_pkg;

  localparam int SA_ARRAY_SIZE = 8;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_W,
    STREAM,
    DRAIN,
    DONE
  } sa_state_t;

  // Precision and signedness applied to a whole tile.
  typedef struct packed {
    logic [3:0] in_width;
    logic [3:0] weight_width;
    logic       s_in;
    logic       s_weight;
  } sa_cfg_t;

endpackage

// File: rtl/sa_valid_pipe.sv
// DEPTH-stage 1-bit shift register with synchronous clear. Tracks which
// array outputs belong to an accepted input vector. DEPTH must be >= 1.
module sa_valid_pipe #(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic clr,
  input  logic din,
  output logic dout
);

  logic [DEPTH-1:0] pipe;

  // Shift din in at stage 0; clear drops every in-flight valid bit.
  always_ff @(posedge clk) begin
    if (clr) begin
      pipe <= '0;
    end else begin
      pipe[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        pipe[i] <= pipe[i-1];
      end
    end
  end

  assign dout = pipe[DEPTH-1];

endmodule

// File: rtl/sa_tile_sequencer.sv
// Tile sequencer for the systolic array: loads the weight bank row by row,
// latches the tile configuration, streams input vectors and flags the
// returning psums with out_valid.
// Optional feature: define SA_CTRL_PERF_EN to build the stall counter
// behind perf_bubbles; otherwise perf_bubbles is tied to zero.
module sa_tile_sequencer
  import sa_pkg::*;
#(
  parameter int ARRAY_SIZE = SA_ARRAY_SIZE,
  parameter int PIPE_LAT   = 1,
  parameter int CNT_W      = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [3:0]                     cfg_in_width,
  input  logic [3:0]                     cfg_weight_width,
  input  logic                           cfg_s_in,
  input  logic                           cfg_s_weight,
  input  logic [CNT_W-1:0]               cfg_num_vecs,
  input  logic                           w_row_valid,
  output logic                           w_row_ready,
  input  logic [ARRAY_SIZE*8-1:0]        w_row_data,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [ARRAY_SIZE*8-1:0]        in_data,
  output logic [ARRAY_SIZE*ARRAY_SIZE*8-1:0] sa_weights,
  output logic [ARRAY_SIZE*8-1:0]        sa_inputs,
  output logic [3:0]                     sa_in_width,
  output logic [3:0]                     sa_weight_width,
  output logic                           sa_s_in,
  output logic                           sa_s_weight,
  input  logic [ARRAY_SIZE*32-1:0]       sa_psums,
  output logic                           out_valid,
  output logic [ARRAY_SIZE*32-1:0]       out_psums,
  output logic                           busy,
  output logic                           done,
  output logic [31:0]                    perf_bubbles
);

  localparam int ROW_W  = ARRAY_SIZE * 8;
  localparam int RCNT_W = (ARRAY_SIZE > 1) ? $clog2(ARRAY_SIZE) : 1;
  localparam int DCNT_W = $clog2(PIPE_LAT + 2);
  localparam logic [RCNT_W-1:0] LAST_ROW = RCNT_W'(ARRAY_SIZE - 1);

  sa_state_t          state, next_state;
  sa_cfg_t            cfg_q;
  logic [CNT_W-1:0]   num_vecs;
  logic [RCNT_W-1:0]  row_cnt;
  logic [CNT_W-1:0]   vec_cnt;
  logic [DCNT_W-1:0]  drain_cnt;
  logic               in_vld_q;
  logic               start_acc;
  logic               w_fire;
  logic               in_fire;

  assign start_acc = (state == IDLE) && start;
  assign w_fire    = w_row_valid && w_row_ready;
  assign in_fire   = in_valid && in_ready;

  // State register; reset aborts any tile in flight.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state decode and per-state handshake/status outputs.
  // NOTE: every output gets a default first, so no path through the case
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    next_state  = state;
    w_row_ready = 1'b0;
    in_ready    = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (state)
      IDLE: begin
        if (start) next_state = LOAD_W;
      end
      LOAD_W: begin
        w_row_ready = 1'b1;
        busy        = 1'b1;
        if (w_row_valid && (row_cnt == LAST_ROW))
          next_state = (num_vecs == '0) ? DONE : STREAM;
      end
      STREAM: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid && (vec_cnt == num_vecs - CNT_W'(1)))
          next_state = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (drain_cnt == '0) next_state = DONE;
      end
      DONE: begin
        done       = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Row/vector counters (saturating at their terminal value) and the
  // drain down-counter, preloaded while outside DRAIN.
  always_ff @(posedge clk) begin
    if (rst) begin
      row_cnt   <= '0;
      vec_cnt   <= '0;
      drain_cnt <= '0;
    end else begin
      if (start_acc) begin
        row_cnt <= '0;
        vec_cnt <= '0;
      end else begin
        if (w_fire && (row_cnt != LAST_ROW))
          row_cnt <= row_cnt + RCNT_W'(1);
        if (in_fire && (vec_cnt != num_vecs - CNT_W'(1)))
          vec_cnt <= vec_cnt + CNT_W'(1);
      end
      if (state != DRAIN)        drain_cnt <= DCNT_W'(PIPE_LAT);
      else if (drain_cnt != '0)  drain_cnt <= drain_cnt - DCNT_W'(1);
    end
  end

  // Tile configuration, captured only on an accepted start.
  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_q    <= '0;
      num_vecs <= '0;
    end else if (start_acc) begin
      cfg_q    <= '{in_width: cfg_in_width, weight_width: cfg_weight_width,
                    s_in: cfg_s_in, s_weight: cfg_s_weight};
      num_vecs <= cfg_num_vecs;
    end
  end

  // Weight bank: one row written per LOAD_W handshake.
  // NOTE: the bank is a flop array with reset on purpose -- a reset must
  // leave the array seeing all-zero weights, not stale tile data.
  always_ff @(posedge clk) begin
    if (rst)         sa_weights <= '0;
    else if (w_fire) sa_weights[int'(row_cnt)*ROW_W +: ROW_W] <= w_row_data;
  end

  // Input register and its valid bit; bubbles drive zeros into the array.
  always_ff @(posedge clk) begin
    if (rst) begin
      sa_inputs <= '0;
      in_vld_q  <= 1'b0;
    end else if (in_fire) begin
      sa_inputs <= in_data;
      in_vld_q  <= 1'b1;
    end else begin
      sa_inputs <= '0;
      in_vld_q  <= 1'b0;
    end
  end

  sa_valid_pipe #(
    .DEPTH (PIPE_LAT)
  ) u_valid_pipe (
    .clk  (clk),
    .clr  (rst),
    .din  (in_vld_q),
    .dout (out_valid)
  );

  assign sa_in_width     = cfg_q.in_width;
  assign sa_weight_width = cfg_q.weight_width;
  assign sa_s_in         = cfg_q.s_in;
  assign sa_s_weight     = cfg_q.s_weight;
  assign out_psums       = sa_psums;

`ifdef SA_CTRL_PERF_EN
  // Stall counter: STREAM cycles without an offered vector, saturating.
  always_ff @(posedge clk) begin
    if (rst || start_acc)
      perf_bubbles <= '0;
    else if ((state == STREAM) && !in_valid && (perf_bubbles != '1))
      perf_bubbles <= perf_bubbles + 32'd1;
  end
`else
  assign perf_bubbles = '0;
`endif

endmodule

// File: tb/tb_sa_tile_sequencer.sv
// Self-checking bench for sa_tile_sequencer. Each tile's expected timeline
// is derived up front from the valid patterns the bench will drive, then
// compared cycle by cycle against the DUT.
module tb_sa_tile_sequencer;

  localparam int AS     = 8;
  localparam int PL     = 1;
  localparam int CW     = 16;
  localparam int MAXC   = 160;
  localparam int ROW_W  = AS * 8;
  localparam int BANK_W = AS * AS * 8;
  localparam int PS_W   = AS * 32;

  logic              clk;
  logic              rst;
  logic              start;
  logic [3:0]        cfg_in_width, cfg_weight_width;
  logic              cfg_s_in, cfg_s_weight;
  logic [CW-1:0]     cfg_num_vecs;
  logic              w_row_valid, w_row_ready;
  logic [ROW_W-1:0]  w_row_data;
  logic              in_valid, in_ready;
  logic [ROW_W-1:0]  in_data;
  logic [BANK_W-1:0] sa_weights;
  logic [ROW_W-1:0]  sa_inputs;
  logic [3:0]        sa_in_width, sa_weight_width;
  logic              sa_s_in, sa_s_weight;
  logic [PS_W-1:0]   sa_psums;
  logic              out_valid;
  logic [PS_W-1:0]   out_psums;
  logic              busy, done;
  logic [31:0]       perf_bubbles;

  sa_tile_sequencer #(
    .ARRAY_SIZE (AS),
    .PIPE_LAT   (PL),
    .CNT_W      (CW)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .cfg_in_width     (cfg_in_width),
    .cfg_weight_width (cfg_weight_width),
    .cfg_s_in         (cfg_s_in),
    .cfg_s_weight     (cfg_s_weight),
    .cfg_num_vecs     (cfg_num_vecs),
    .w_row_valid      (w_row_valid),
    .w_row_ready      (w_row_ready),
    .w_row_data       (w_row_data),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_data          (in_data),
    .sa_weights       (sa_weights),
    .sa_inputs        (sa_inputs),
    .sa_in_width      (sa_in_width),
    .sa_weight_width  (sa_weight_width),
    .sa_s_in          (sa_s_in),
    .sa_s_weight      (sa_s_weight),
    .sa_psums         (sa_psums),
    .out_valid        (out_valid),
    .out_psums        (out_psums),
    .busy             (busy),
    .done             (done),
    .perf_bubbles     (perf_bubbles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_fail;

  // Expected timeline of the current tile, indexed by cycle after start.
  bit               ex_wr[MAXC], ex_ir[MAXC], ex_busy[MAXC], ex_done[MAXC], ex_ov[MAXC];
  bit               wv[MAXC], iv[MAXC];
  logic [ROW_W-1:0] ex_in[MAXC], wdat_at[MAXC], idat_at[MAXC];
  logic [ROW_W-1:0] wrows[AS];
  logic [BANK_W-1:0] bank_exp;

  task automatic check(input string tag, input logic [BANK_W-1:0] got,
                       input logic [BANK_W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [ROW_W-1:0] rand_row();
    return {$urandom, $urandom};
  endfunction

  // mode 0: all valids high, row r filled with r+1
  // mode 1: weights high, in_valid 1,0,1,0 from the first STREAM cycle
  // mode 2: random valids and data
  task automatic run_tile(input int tile, input int nv, input int mode, input bit abort);
    int rows, vecs, load_end, done_c, abort_c, last, bub;
    logic [3:0]        iw, ww;
    bit                si, sw;
    logic [31:0]       ex_bub;
    logic [BANK_W-1:0] bank_new;
    logic [PS_W-1:0]   psums;
    string             p;

    iw = 4'($urandom_range(1, 15));
    ww = 4'($urandom_range(1, 15));
    si = 1'($urandom);
    sw = 1'($urandom);
    for (int c = 0; c < MAXC; c++) begin
      ex_wr[c] = 0; ex_ir[c] = 0; ex_busy[c] = 0; ex_done[c] = 0; ex_ov[c] = 0;
      ex_in[c] = '0;
      wdat_at[c] = rand_row();
      idat_at[c] = rand_row();
      wv[c] = (mode == 2) ? (($urandom_range(0, 3) != 0) || c >= 100) : 1'b1;
      iv[c] = (mode == 2) ? (($urandom_range(0, 2) != 0) || c >= 100) : (mode == 0);
    end
    for (int r = 0; r < AS; r++)
      wrows[r] = (mode == 0) ? {AS{8'(r + 1)}} : rand_row();

    // Weight phase: one row per cycle that offers one, starting after start.
    rows = 0;
    last = 1;
    while (rows < AS) begin
      ex_wr[last] = 1; ex_busy[last] = 1;
      wdat_at[last] = wrows[rows];
      if (wv[last]) rows++;
      last++;
    end
    load_end = last;
    bank_new = '0;
    for (int r = 0; r < AS; r++) bank_new[r*ROW_W +: ROW_W] = wrows[r];

    if (mode == 1) begin
      iv[load_end] = 1; iv[load_end+1] = 0; iv[load_end+2] = 1; iv[load_end+3] = 0;
    end

    // Stream phase, then PL+1 drain cycles.
    vecs = 0; bub = 0; abort_c = -1;
    if (nv > 0) begin
      while (vecs < nv) begin
        ex_ir[last] = 1; ex_busy[last] = 1;
        if (iv[last]) begin
          ex_in[last+1] = idat_at[last];
          ex_ov[last+1+PL] = 1;
          vecs++;
          if (vecs == 2) abort_c = last + 1;
        end else begin
          bub++;
        end
        last++;
      end
      for (int k = 0; k <= PL; k++) begin
        ex_busy[last] = 1;
        last++;
      end
    end
    done_c = last;
    ex_done[done_c] = 1;
`ifdef SA_CTRL_PERF_EN
    ex_bub = 32'(bub);
`else
    ex_bub = 32'd0;
`endif
    last = abort ? abort_c + 1 : done_c + 1;

    for (int c = 0; c <= last; c++) begin
      start = (c == 0) || (c == 3) || (c == done_c);
      if (c == 0) begin
        cfg_in_width = iw; cfg_weight_width = ww; cfg_s_in = si; cfg_s_weight = sw;
        cfg_num_vecs = CW'(nv);
      end else begin
        cfg_in_width = ~iw; cfg_weight_width = 4'($urandom);
        cfg_s_in = 1'($urandom); cfg_s_weight = 1'($urandom);
        cfg_num_vecs = CW'($urandom);
      end
      w_row_valid = wv[c]; w_row_data = wdat_at[c];
      in_valid = iv[c];    in_data = idat_at[c];
      rst = abort && (c == abort_c);
      for (int i = 0; i < AS; i++) psums[i*32 +: 32] = $urandom;
      sa_psums = psums;
      @(negedge clk);
      p = $sformatf("t%0d c%0d", tile, c);
      if (abort && c == abort_c + 1) begin
        check({p, " abort busy"}, busy, 1'b0);
        check({p, " abort done"}, done, 1'b0);
        check({p, " abort out_valid"}, out_valid, 1'b0);
        check({p, " abort w_row_ready"}, w_row_ready, 1'b0);
        check({p, " abort in_ready"}, in_ready, 1'b0);
        check({p, " abort sa_weights"}, sa_weights, '0);
        check({p, " abort sa_inputs"}, sa_inputs, '0);
        check({p, " abort sa_in_width"}, sa_in_width, 4'd0);
      end else begin
        check({p, " w_row_ready"}, w_row_ready, ex_wr[c]);
        check({p, " in_ready"}, in_ready, ex_ir[c]);
        check({p, " busy"}, busy, ex_busy[c]);
        check({p, " done"}, done, ex_done[c]);
        check({p, " out_valid"}, out_valid, ex_ov[c]);
        check({p, " sa_inputs"}, sa_inputs, ex_in[c]);
        if (c >= 1)
          check({p, " cfg"}, {sa_in_width, sa_weight_width, sa_s_in, sa_s_weight},
                {iw, ww, si, sw});
        if (ex_ov[c]) check({p, " out_psums"}, out_psums, psums);
        if (c == 0) check({p, " bank held"}, sa_weights, bank_exp);
        if (c == load_end || c == done_c) check({p, " bank"}, sa_weights, bank_new);
        if (c == done_c || c == done_c + 1) check({p, " perf_bubbles"}, perf_bubbles, ex_bub);
      end
      @(posedge clk);
      #1;
    end
    start = 1'b0; w_row_valid = 1'b0; in_valid = 1'b0; rst = 1'b0;
    bank_exp = abort ? '0 : bank_new;
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    start = 0; cfg_in_width = 0; cfg_weight_width = 0; cfg_s_in = 0; cfg_s_weight = 0;
    cfg_num_vecs = 0; w_row_valid = 0; w_row_data = 0; in_valid = 0; in_data = 0;
    sa_psums = 0;
    bank_exp = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset busy", busy, 1'b0);
    check("reset done", done, 1'b0);
    check("reset out_valid", out_valid, 1'b0);
    check("reset readies", {w_row_ready, in_ready}, 2'b00);
    check("reset sa_weights", sa_weights, '0);
    check("reset sa_inputs", sa_inputs, '0);
    check("reset cfg", {sa_in_width, sa_weight_width, sa_s_in, sa_s_weight}, 10'd0);
    check("reset perf_bubbles", perf_bubbles, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    run_tile(0, 4, 0, 1'b0);   // valids held high, row r = r+1
    run_tile(1, 2, 1, 1'b0);   // in_valid 1,0,1,0
    run_tile(2, 0, 2, 1'b0);   // empty tile
    run_tile(3, 5, 0, 1'b1);   // reset after two vectors
    run_tile(4, 3, 0, 1'b0);   // clean tile after the abort
    for (int t = 5; t < 11; t++)
      run_tile(t, $urandom_range(0, 7), 2, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
